// File: rtl/fir_out_if.sv
// FIR output stage bus: chain-tail input, consumer handshake, status flags.
// Optional sat_count member is present when FIR_OUT_SAT_CNT_EN is defined.
interface fir_out_if #(
    parameter int IN_W       = 13,
    parameter int OUT_W      = 12,
    parameter int FIFO_DEPTH = 8
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                    in_valid;
    logic signed [IN_W-1:0]  acc_in;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sat_flag;
    logic                    ovf_flag;
    logic                    flag_clr;
    logic [LW-1:0]           fifo_level;
`ifdef FIR_OUT_SAT_CNT_EN
    logic [15:0]             sat_count;

    modport master (
        output in_valid, acc_in, out_ready, flag_clr,
        input  out_data, out_valid, sat_flag, ovf_flag, fifo_level, sat_count
    );
    modport slave (
        input  in_valid, acc_in, out_ready, flag_clr,
        output out_data, out_valid, sat_flag, ovf_flag, fifo_level, sat_count
    );
`else
    modport master (
        output in_valid, acc_in, out_ready, flag_clr,
        input  out_data, out_valid, sat_flag, ovf_flag, fifo_level
    );
    modport slave (
        input  in_valid, acc_in, out_ready, flag_clr,
        output out_data, out_valid, sat_flag, ovf_flag, fifo_level
    );
`endif
endinterface

// File: rtl/fir_out_stage.sv
// FIR output stage: valid alignment, round/shift/saturate, FWFT output FIFO.
// Define FIR_OUT_SAT_CNT_EN to add the 16-bit saturating sat_count output.
module fir_out_stage #(
    parameter int IN_W       = 13,
    parameter int OUT_W      = 12,
    parameter int FRAC_SHIFT = 1,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input logic     clock,
    input logic     reset,
    fir_out_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int RS = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
    localparam logic signed [IN_W:0] RND  =
        (FRAC_SHIFT > 0) ? (IN_W+1)'(1 << RS) : '0;
    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] MINV = (IN_W+1)'(-(1 << (OUT_W-1)));

    logic [LATENCY-1:0]      r_vpipe;
    logic                    w_vd;
    logic signed [IN_W:0]    w_t;
    logic signed [IN_W:0]    w_r;
    logic                    w_hi;
    logic                    w_lo;
    logic [OUT_W-1:0]        w_res;
    logic [OUT_W-1:0]        r_data;
    logic                    r_wr;
    logic [OUT_W-1:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wptr;
    logic [AW-1:0]           r_rptr;
    logic [LW-1:0]           r_level;
    logic                    r_sat;
    logic                    r_ovf;
    logic                    w_valid;
    logic                    w_full;
    logic                    w_rd;
    logic                    w_wr_ok;
    logic                    w_drop;
    logic                    w_sat_ev;

    generate
        if (LATENCY == 1) begin : g_pipe1
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) r_vpipe <= '0;
                else        r_vpipe <= bus.in_valid;
            end
        end else begin : g_pipen
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) r_vpipe <= '0;
                else        r_vpipe <= {r_vpipe[LATENCY-2:0], bus.in_valid};
            end
        end
    endgenerate

    assign w_vd = r_vpipe[LATENCY-1];

    // Sign-extend one bit so the rounding add cannot wrap.
    always_comb begin
        w_t   = {bus.acc_in[IN_W-1], bus.acc_in} + RND;
        w_r   = w_t >>> FRAC_SHIFT;
        w_hi  = w_r > MAXV;
        w_lo  = w_r < MINV;
        w_res = w_r[OUT_W-1:0];
        if (w_hi)      w_res = {1'b0, {(OUT_W-1){1'b1}}};
        else if (w_lo) w_res = {1'b1, {(OUT_W-1){1'b0}}};
    end

    assign w_sat_ev = w_vd & (w_hi | w_lo);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr   <= 1'b0;
            r_data <= '0;
        end else begin
            r_wr <= w_vd;
            if (w_vd) r_data <= w_res;
        end
    end

    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == LW'(FIFO_DEPTH));
    assign w_rd    = w_valid & bus.out_ready;
    assign w_wr_ok = r_wr & (~w_full | w_rd);
    assign w_drop  = r_wr & w_full & ~w_rd;

    always_ff @(posedge clock) begin
        if (w_wr_ok) r_mem[r_wptr] <= r_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + AW'(1);
            if (w_rd)    r_rptr <= r_rptr + AW'(1);
            if (w_wr_ok && !w_rd)      r_level <= r_level + LW'(1);
            else if (!w_wr_ok && w_rd) r_level <= r_level - LW'(1);
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sat <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_sat_ev)          r_sat <= 1'b1;
            else if (bus.flag_clr) r_sat <= 1'b0;
            if (w_drop)            r_ovf <= 1'b1;
            else if (bus.flag_clr) r_ovf <= 1'b0;
        end
    end

`ifdef FIR_OUT_SAT_CNT_EN
    logic [15:0] r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (bus.flag_clr) begin
            r_cnt <= {15'd0, w_sat_ev};
        end else if (w_sat_ev && r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign bus.sat_count = r_cnt;
`endif

    assign bus.out_data   = w_valid ? r_mem[r_rptr] : '0;
    assign bus.out_valid  = w_valid;
    assign bus.fifo_level = r_level;
    assign bus.sat_flag   = r_sat;
    assign bus.ovf_flag   = r_ovf;
endmodule

// File: tb/tb_fir_out_stage.sv
// Directed bench for fir_out_stage: rounding table, FIFO overflow,
// full read/write collision, flag clearing and mid-run reset.
module tb_fir_out_stage;
    localparam int IN_W  = 13;
    localparam int OUT_W = 12;
    localparam int DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    fir_out_if #(.IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)) bus ();

    fir_out_stage #(
        .IN_W(IN_W), .OUT_W(OUT_W), .FRAC_SHIFT(1),
        .LATENCY(4), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int acc;
        int exp_d;
        int exp_sat;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr_pulse();
        @(negedge clock);
        bus.flag_clr = 1'b1;
        @(negedge clock);
        bus.flag_clr = 1'b0;
    endtask

    // in_valid sampled at edge p0; acc_in presented for edge p4.
    // Returns at the negedge after p5, where out_valid must be high.
    task automatic send_one(input int acc, input bit clr_ld);
        @(negedge clock);
        bus.in_valid = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        bus.acc_in   = IN_W'(acc);
        bus.flag_clr = clr_ld;
        @(negedge clock);
        bus.acc_in   = '0;
        bus.flag_clr = 1'b0;
        chk("latency_early", 32'(bus.out_valid), 0);
        @(negedge clock);
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int seen;

        vt[0]  = '{5, 3, 0};
        vt[1]  = '{-5, -2, 0};
        vt[2]  = '{-4096, -2048, 0};
        vt[3]  = '{4095, 2047, 1};
        vt[4]  = '{0, 0, 0};
        vt[5]  = '{1, 1, 0};
        vt[6]  = '{-1, 0, 0};
        vt[7]  = '{2, 1, 0};
        vt[8]  = '{-2, -1, 0};
        vt[9]  = '{4094, 2047, 0};
        vt[10] = '{-4095, -2047, 0};
        vt[11] = '{3, 2, 0};

        bus.in_valid  = 1'b0;
        bus.acc_in    = '0;
        bus.out_ready = 1'b0;
        bus.flag_clr  = 1'b0;

        #1;
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_level", 32'(bus.fifo_level), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        chk("rst_sat", 32'(bus.sat_flag), 0);
        chk("rst_ovf", 32'(bus.ovf_flag), 0);
`ifdef FIR_OUT_SAT_CNT_EN
        chk("rst_cnt", 32'(bus.sat_count), 0);
`endif
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 12; i++) begin
            clr_pulse();
            send_one(vt[i].acc, 1'b0);
            chk($sformatf("valid_%0d", vt[i].acc), 32'(bus.out_valid), 1);
            chk($sformatf("data_%0d", vt[i].acc), 32'(bus.out_data), vt[i].exp_d);
            chk($sformatf("sat_%0d", vt[i].acc), 32'(bus.sat_flag), vt[i].exp_sat);
            chk($sformatf("lvl_%0d", vt[i].acc), 32'(bus.fifo_level), 1);
            pop_one();
            chk($sformatf("empty_%0d", vt[i].acc), 32'(bus.out_valid), 0);
        end

        clr_pulse();
        send_one(4095, 1'b1);
        chk("sat_set_wins", 32'(bus.sat_flag), 1);
        chk("sat_hold_data", 32'(bus.out_data), 2047);
`ifdef FIR_OUT_SAT_CNT_EN
        chk("cnt_set_wins", 32'(bus.sat_count), 1);
`endif
        pop_one();
        bus.flag_clr = 1'b1;
        @(negedge clock);
        bus.flag_clr = 1'b0;
        chk("sat_clr", 32'(bus.sat_flag), 0);
`ifdef FIR_OUT_SAT_CNT_EN
        chk("cnt_clr", 32'(bus.sat_count), 0);
`endif

        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            bus.in_valid = (c < 10);
            bus.acc_in   = (c >= 4 && c < 14) ? IN_W'(2 * (c - 4)) : '0;
        end
        @(negedge clock);
        chk("ovf_level", 32'(bus.fifo_level), 8);
        chk("ovf_flag", 32'(bus.ovf_flag), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("hold_data", 32'(bus.out_data), 0);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_%0d", i), 32'(bus.out_data), i);
            @(negedge clock);
        end
        bus.out_ready = 1'b0;
        chk("drain_empty", 32'(bus.out_valid), 0);

        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            bus.in_valid = (c < 6);
            bus.acc_in   = (c == 4) ? IN_W'(4095) :
                           (c >= 5) ? IN_W'(2 * (c - 4)) : '0;
        end
        @(negedge clock);
        chk("pre_rst_level", 32'(bus.fifo_level), 3);
        chk("pre_rst_sat", 32'(bus.sat_flag), 1);
        bus.in_valid = 1'b0;
        bus.acc_in   = '0;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_level", 32'(bus.fifo_level), 0);
        chk("mid_rst_sat", 32'(bus.sat_flag), 0);
        chk("mid_rst_ovf", 32'(bus.ovf_flag), 0);
`ifdef FIR_OUT_SAT_CNT_EN
        chk("mid_rst_cnt", 32'(bus.sat_count), 0);
`endif
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (bus.out_valid) seen++;
        end
        chk("no_stale", seen, 0);
        chk("post_rst_level", 32'(bus.fifo_level), 0);

        clr_pulse();
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            bus.in_valid  = (c < 9);
            bus.acc_in    = (c >= 4 && c < 13) ? IN_W'(2 * (c - 4)) : '0;
            bus.out_ready = (c == 13);
        end
        @(negedge clock);
        bus.out_ready = 1'b0;
        chk("full_rw_level", 32'(bus.fifo_level), 8);
        chk("full_rw_ovf", 32'(bus.ovf_flag), 0);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("full_rw_%0d", i), 32'(bus.out_data), i);
            @(negedge clock);
        end
        bus.out_ready = 1'b0;
        chk("full_rw_empty", 32'(bus.out_valid), 0);
        chk("full_rw_lvl0", 32'(bus.fifo_level), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
